// File: rtl/expr_emit.sv
// expr_emit: serialises a packed "digit (op digit)*" expression into an ASCII
// character stream with a valid/ready handshake, one character per transfer.
module expr_emit #(
    parameter int MAX_TERMS = 4
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   start,
    input  logic [3:0]             n_terms,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [MAX_TERMS-2:0]   ops,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_char,
    output logic                   out_last,
    output logic                   busy,
    output logic                   err
);

    // Operand storage is rounded up to a power of two so idx can never
    // address past the end of the latched arrays.
    localparam int IDX_W = $clog2(MAX_TERMS);
    localparam int DEPTH = 1 << IDX_W;
    localparam int DIG_W = 4 * DEPTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIG  = 2'd1,
        OP   = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic                    err_reg, err_next;
    logic [3:0]              n_reg;
    logic [DEPTH-1:0][3:0]   dig_reg;
    logic [DEPTH-1:0]        ops_reg;
    logic [IDX_W-1:0]        idx_reg;

    logic                    load;
    logic                    reject;
    logic                    is_last;
    logic [3:0]              cur_digit;
    logic [MAX_TERMS-1:0]    bad_term;

    // A term only matters if it lies inside the requested length.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_TERMS; gi++) begin : g_term_check
            assign bad_term[gi] = (n_terms > 4'(gi)) && (digits[4*gi +: 4] > 4'd9);
        end
    endgenerate

    assign reject    = (n_terms == 4'd0) || (n_terms > 4'(MAX_TERMS)) || (|bad_term);
    assign cur_digit = dig_reg[idx_reg];
    assign is_last   = (4'(idx_reg) == (n_reg - 4'd1));
    assign busy      = (state_reg != IDLE);
    assign err       = err_reg;

    // Next-state and handshake outputs; the character is derived from the
    // held registers, so it stays stable while the sink stalls.
    always_comb begin
        state_next = state_reg;
        err_next   = 1'b0;
        load       = 1'b0;
        out_valid  = 1'b0;
        out_char   = 8'h00;
        out_last   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (reject) begin
                        err_next = 1'b1;
                    end else begin
                        load       = 1'b1;
                        state_next = DIG;
                    end
                end
            end
            DIG: begin
                out_valid = 1'b1;
                out_char  = 8'h30 + {4'h0, cur_digit};
                out_last  = is_last;
                if (out_ready) begin
                    state_next = is_last ? IDLE : OP;
                end
            end
            OP: begin
                out_valid = 1'b1;
                out_char  = ops_reg[idx_reg] ? 8'h2A : 8'h2B;
                if (out_ready) begin
                    state_next = DIG;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and the one-cycle reject pulse.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= IDLE;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
        end
    end

    // Request latch and term index; inputs are ignored once a stream is in flight.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            n_reg   <= 4'd0;
            dig_reg <= '0;
            ops_reg <= '0;
            idx_reg <= '0;
        end else if (load) begin
            n_reg   <= n_terms;
            dig_reg <= DIG_W'(digits);
            ops_reg <= DEPTH'(ops);
            idx_reg <= '0;
        end else if ((state_reg == OP) && out_ready) begin
            idx_reg <= idx_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_expr_emit.sv
// tb_expr_emit: randomized and directed checks of expr_emit against a
// queue-based model that expands each accepted request into its character list.
module tb_expr_emit;

    localparam int MT = 4;

    typedef logic [8:0] ent_t;      // {last, char}
    typedef ent_t ent_q_t[$];

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    n_terms = 4'd0;
    logic [4*MT-1:0] digits = '0;
    logic [MT-2:0] ops = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [7:0]    out_char;
    logic          out_last;
    logic          busy;
    logic          err;

    expr_emit #(.MAX_TERMS(MT)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .n_terms   (n_terms),
        .digits    (digits),
        .ops       (ops),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the whole character list an accepted request must produce,
    // or an empty list when the request must be rejected.
    function automatic ent_q_t build_stream(input int n, input logic [4*MT-1:0] d,
                                            input logic [MT-2:0] o);
        ent_q_t q;
        bit bad;
        q = {};
        bad = (n == 0) || (n > MT);
        for (int k = 0; k < n && k < MT; k++)
            if (d[4*k +: 4] > 4'd9) bad = 1;
        if (!bad) begin
            for (int k = 0; k < n; k++) begin
                q.push_back({(k == n - 1), 8'(8'h30 + d[4*k +: 4])});
                if (k < n - 1)
                    q.push_back({1'b0, (o[k] ? 8'h2A : 8'h2B)});
            end
        end
        return q;
    endfunction

    ent_q_t     exp_q;
    logic       err_exp = 1'b0;
    logic [7:0] got_q[$];
    int         busy_cnt = 0;
    int         xfer_cnt = 0;
    int         err_cnt = 0;
    logic       prev_stall = 1'b0;
    ent_t       prev_ent = '0;

    // Compare process: check outputs mid-cycle, then advance the model by
    // what the coming clock edge will do with the current inputs.
    always @(negedge clk) begin
        ent_q_t tmp;
        if (!clr_n) begin
            exp_q.delete();
            err_exp    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("err", 32'(err), 32'(err_exp));
            chk("busy", 32'(busy), 32'(exp_q.size() > 0));
            chk("valid", 32'(out_valid), 32'(exp_q.size() > 0));
            if (out_valid && exp_q.size() > 0) begin
                chk("char", 32'(out_char), 32'(exp_q[0][7:0]));
                chk("last", 32'(out_last), 32'(exp_q[0][8]));
            end else if (!out_valid) begin
                chk("idle_char", 32'({out_last, out_char}), 32'(0));
            end
            if (prev_stall)
                chk("stall_hold", 32'({out_valid, out_last, out_char}), 32'({1'b1, prev_ent}));
            if (busy) busy_cnt++;
            if (err) err_cnt++;

            err_exp = 1'b0;
            if (exp_q.size() > 0) begin
                prev_stall = out_valid && !out_ready;
                prev_ent   = {out_last, out_char};
                if (out_ready) begin
                    got_q.push_back(out_char);
                    xfer_cnt++;
                    void'(exp_q.pop_front());
                end
            end else begin
                prev_stall = 1'b0;
                if (start) begin
                    tmp = build_stream(int'(n_terms), digits, ops);
                    if (tmp.size() == 0) err_exp = 1'b1;
                    else exp_q = tmp;
                end
            end
        end
    end

    task automatic req(input logic [3:0] n, input logic [4*MT-1:0] d, input logic [MT-2:0] o);
        start = 1'b1; n_terms = n; digits = d; ops = o;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy && exp_q.size() == 0) return;
            @(posedge clk); #1;
        end
        chk("wait_idle_timeout", 32'(busy), 32'(0));
    endtask

    // Asynchronous mid-cycle reset; called from just after a rising edge.
    task automatic reset_mid();
        start = 1'b0;
        #2 clr_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_char", 32'(out_char), 32'(0));
        chk("rst_last", 32'(out_last), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        @(posedge clk); #1;
        clr_n = 1'b1;
    endtask

    task automatic chk_got(input string name, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                           input int n);
        logic [7:0] e[5];
        e = '{e0, e1, e2, e3, e4};
        chk({name, "_len"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk(name, 32'(got_q[i]), 32'(e[i]));
    endtask

    initial begin
        ent_q_t q;

        // Reset state
        #2;
        chk("init_valid", 32'(out_valid), 32'(0));
        chk("init_char", 32'(out_char), 32'(0));
        chk("init_busy", 32'(busy), 32'(0));
        chk("init_err", 32'(err), 32'(0));
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;

        // Pin the model with hand-computed streams
        q = build_stream(3, 16'h0753, 3'b010);
        chk("model_len3", 32'(q.size()), 32'(5));
        if (q.size() == 5) begin
            chk("model_c0", 32'(q[0]), 32'(9'h033));
            chk("model_c1", 32'(q[1]), 32'(9'h02B));
            chk("model_c2", 32'(q[2]), 32'(9'h035));
            chk("model_c3", 32'(q[3]), 32'(9'h02A));
            chk("model_c4", 32'(q[4]), 32'(9'h137));
        end
        q = build_stream(1, 16'h0009, 3'b000);
        chk("model_single", 32'(q.size() == 1 ? q[0] : 9'h0), 32'(9'h139));
        q = build_stream(2, 16'h00A3, 3'b000);
        chk("model_baddigit", 32'(q.size()), 32'(0));

        // Back-to-back stream with ready held high
        out_ready = 1'b1;
        got_q.delete();
        req(4'd3, 16'h0753, 3'b010);
        wait_idle();
        chk_got("b2b", 8'h33, 8'h2B, 8'h35, 8'h2A, 8'h37, 5);

        // Same request under a 1,0,0,1 ready pattern
        got_q.delete();
        out_ready = 1'b1;
        req(4'd3, 16'h0753, 3'b010);
        for (int c = 1; c < 80 && (busy || exp_q.size() > 0); c++) begin
            out_ready = (c % 3) == 0;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle();
        chk_got("stall", 8'h33, 8'h2B, 8'h35, 8'h2A, 8'h37, 5);

        // Single term: one char, busy exactly one cycle
        got_q.delete();
        busy_cnt = 0;
        req(4'd1, 16'h0009, 3'b000);
        wait_idle();
        chk("single_busy_cycles", 32'(busy_cnt), 32'(1));
        chk_got("single", 8'h39, 8'h00, 8'h00, 8'h00, 8'h00, 1);

        // Rejected requests
        got_q.delete();
        err_cnt = 0;
        req(4'd0, 16'h1111, 3'b000);
        @(posedge clk); #1;
        req(4'd5, 16'h1111, 3'b000);
        @(posedge clk); #1;
        req(4'd2, 16'h00A3, 3'b000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reject_err_pulses", 32'(err_cnt), 32'(3));
        chk("reject_no_chars", 32'(got_q.size()), 32'(0));

        // start while busy is ignored; reset after the 2nd char aborts
        got_q.delete();
        xfer_cnt = 0;
        req(4'd3, 16'h0246, 3'b011);
        start = 1'b1; n_terms = 4'd2; digits = 16'h0011; ops = 3'b000;
        for (int i = 0; i < 50 && xfer_cnt < 2; i++) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("abort_after_two", 32'(xfer_cnt), 32'(2));
        reset_mid();
        chk_got("abort", 8'h36, 8'h2A, 8'h00, 8'h00, 8'h00, 2);
        got_q.delete();
        req(4'd2, 16'h0021, 3'b001);
        wait_idle();
        chk_got("after_rst", 8'h31, 8'h2A, 8'h32, 8'h00, 8'h00, 3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [4*MT-1:0] d;
            for (int k = 0; k < MT; k++)
                d[4*k +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                          : 4'($urandom_range(0, 9));
            start     = ($urandom_range(0, 3) == 0);
            n_terms   = 4'($urandom_range(0, 5));
            digits    = d;
            ops       = 3'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
